cdb_broadcast_queue: RTL and testbench

- Sits directly downstream of the functional units (FU_ADD, FU_SRA, …).
- Latches each FU's one-cycle done pulse as a pending request and arbitrates round-robin among pending FUs.
- Writes one {tag, result} per cycle into a FIFO and returns a one-cycle queued pulse to the winning FU, which lets that FU go idle.
- FIFO head drives the common data bus (CDB) toward the reservation stations and the register file.

---
 rtl/cdb_broadcast_queue.sv | 143 ++++++++++++++
 tb/tb_cdb_broadcast_queue.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_broadcast_queue.sv
`default_nettype none
// ============================================================================
// Module   : cdb_broadcast_queue
// Purpose  : Captures FU done pulses, grants them round-robin into a FIFO and
//            presents the FIFO head (show-ahead) on the common data bus.
// Revision : 1.0
// ============================================================================

module cdb_broadcast_queue #(
  parameter int NUM_FU     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 7,
  parameter int DEPTH      = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_FU-1:0]                fu_done,
  input  logic [NUM_FU*TAG_WIDTH-1:0]      fu_tag,
  input  logic [NUM_FU*DATA_WIDTH-1:0]     fu_result,
  output logic [NUM_FU-1:0]                fu_queued,
  output logic                             cdb_valid,
  output logic [TAG_WIDTH-1:0]             cdb_tag,
  output logic [DATA_WIDTH-1:0]            cdb_data,
  input  logic                             cdb_stall,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(DEPTH):0]           count
);

  localparam int RR_W     = $clog2(NUM_FU);
  localparam int SUM_W    = RR_W + 1;
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int ENTRY_W  = TAG_WIDTH + DATA_WIDTH;

  localparam logic [SUM_W-1:0] NUM_FU_W = SUM_W'(NUM_FU);
  localparam logic [RR_W-1:0]  LAST_FU  = RR_W'(NUM_FU - 1);
  localparam logic [CNT_W-1:0] DEPTH_W  = CNT_W'(DEPTH);

  logic [NUM_FU-1:0]     pending_q, pending_d;
  logic [NUM_FU-1:0]     grant;
  logic [RR_W-1:0]       rr_q, rr_d;
  logic [RR_W-1:0]       grant_idx;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [ENTRY_W-1:0]    mem_q [DEPTH];
  logic [ENTRY_W-1:0]    head;
  logic [ENTRY_W-1:0]    wr_entry;
  logic [TAG_WIDTH-1:0]  tag_arr [NUM_FU];
  logic [DATA_WIDTH-1:0] res_arr [NUM_FU];
  logic                  push;
  logic                  pop;
  logic                  space_ok;
  logic                  found;
  logic [SUM_W-1:0]      idx_sum;
  logic [RR_W-1:0]       idx;

  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_unpack
    assign tag_arr[gi] = fu_tag[gi*TAG_WIDTH +: TAG_WIDTH];
    assign res_arr[gi] = fu_result[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_W);
  assign count     = count_q;
  assign cdb_valid = ~empty;
  assign pop       = cdb_valid & ~cdb_stall;
  // A pop in the same cycle frees the slot the new entry lands in.
  assign space_ok  = ~full | pop;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx_sum   = '0;
    idx       = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx_sum = {1'b0, rr_q} + SUM_W'(k);
      if (idx_sum >= NUM_FU_W) begin
        idx_sum = idx_sum - NUM_FU_W;
      end
      idx = idx_sum[RR_W-1:0];
      if (!found && space_ok && pending_q[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  assign push      = found;
  assign fu_queued = grant;
  assign wr_entry  = {tag_arr[grant_idx], res_arr[grant_idx]};

  always_comb begin
    pending_d = (pending_q | fu_done) & ~grant;

    rr_d = rr_q;
    if (push) begin
      rr_d = (grant_idx == LAST_FU) ? '0 : grant_idx + RR_W'(1);
    end

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      rr_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      rr_q      <= rr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign head     = mem_q[rd_ptr_q];
  assign cdb_tag  = cdb_valid ? head[ENTRY_W-1 -: TAG_WIDTH] : '0;
  assign cdb_data = cdb_valid ? head[DATA_WIDTH-1:0] : '0;

endmodule

`default_nettype wire

// File: tb/tb_cdb_broadcast_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_broadcast_queue
// Purpose  : Directed table, corner-case sequences and random traffic for
//            cdb_broadcast_queue against a queue-based reference model.
// Revision : 1.0
// ============================================================================

module tb_cdb_broadcast_queue;

  localparam int NF = 4;
  localparam int DW = 32;
  localparam int TW = 7;
  localparam int D  = 8;

  logic              clk;
  logic              rst;
  logic [NF-1:0]     fu_done;
  logic [NF*TW-1:0]  fu_tag;
  logic [NF*DW-1:0]  fu_result;
  logic [NF-1:0]     fu_queued;
  logic              cdb_valid;
  logic [TW-1:0]     cdb_tag;
  logic [DW-1:0]     cdb_data;
  logic              cdb_stall;
  logic              full;
  logic              empty;
  logic [$clog2(D):0] count;

  cdb_broadcast_queue #(
    .NUM_FU(NF), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst), .fu_done(fu_done), .fu_tag(fu_tag),
    .fu_result(fu_result), .fu_queued(fu_queued), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_stall(cdb_stall),
    .full(full), .empty(empty), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: pending set, rotating start index, FIFO as a queue.
  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } ent_t;

  ent_t        m_q[$];
  bit [NF-1:0] m_pend;
  int          m_rr;
  int          m_grant;
  bit          m_pop;

  task automatic model_clear();
    m_q.delete();
    m_pend = '0;
    m_rr   = 0;
  endtask

  task automatic step();
    logic [NF-1:0] exp_q;
    bit space;
    ent_t e;
    m_pop   = (m_q.size() > 0) && !cdb_stall;
    space   = (m_q.size() < D) || m_pop;
    m_grant = -1;
    for (int k = 0; k < NF; k++) begin
      int i;
      i = (m_rr + k) % NF;
      if (m_grant < 0 && space && m_pend[i]) m_grant = i;
    end
    exp_q = '0;
    if (m_grant >= 0) exp_q[m_grant] = 1'b1;
    chk("queued", 64'(fu_queued), 64'(exp_q));
    chk("valid", 64'(cdb_valid), 64'(m_q.size() > 0));
    chk("tag", 64'(cdb_tag), (m_q.size() > 0) ? 64'(m_q[0].tag) : 64'd0);
    chk("data", 64'(cdb_data), (m_q.size() > 0) ? 64'(m_q[0].data) : 64'd0);
    chk("count", 64'(count), 64'(m_q.size()));
    chk("full", 64'(full), 64'(m_q.size() == D));
    chk("empty", 64'(empty), 64'(m_q.size() == 0));
    if (rst) begin
      model_clear();
    end else begin
      if (m_pop) void'(m_q.pop_front());
      if (m_grant >= 0) begin
        e.tag  = fu_tag[m_grant*TW +: TW];
        e.data = fu_result[m_grant*DW +: DW];
        m_q.push_back(e);
      end
      for (int i = 0; i < NF; i++) m_pend[i] = (m_pend[i] | fu_done[i]) && (i != m_grant);
      if (m_grant >= 0) m_rr = (m_grant + 1) % NF;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu(input int i, input logic [TW-1:0] t, input logic [DW-1:0] r);
    fu_tag[i*TW +: TW]    = t;
    fu_result[i*DW +: DW] = r;
  endtask

  typedef struct packed {
    logic          rst;
    logic [NF-1:0] done;
    logic          stall;
    logic [NF-1:0] exp_q;
    logic          exp_valid;
    logic [TW-1:0] exp_tag;
    logic [3:0]    exp_count;
  } vec_t;

  vec_t tbl [19];
  bit   busy [NF];

  initial begin
    logic [TW-1:0] last_tag;
    int pulses;

    tbl[0]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 7'd0,  4'd0};
    tbl[1]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 7'd0,  4'd0};
    tbl[2]  = '{1'b0, 4'b0000, 1'b1, 4'b0001, 1'b0, 7'd0,  4'd0};
    tbl[3]  = '{1'b0, 4'b0000, 1'b1, 4'b0010, 1'b1, 7'd10, 4'd1};
    tbl[4]  = '{1'b0, 4'b0000, 1'b1, 4'b0100, 1'b1, 7'd10, 4'd2};
    tbl[5]  = '{1'b0, 4'b0000, 1'b1, 4'b1000, 1'b1, 7'd10, 4'd3};
    tbl[6]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 7'd10, 4'd4};
    tbl[7]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 7'd10, 4'd4};
    tbl[8]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 7'd11, 4'd3};
    tbl[9]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 7'd12, 4'd2};
    tbl[10] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 7'd13, 4'd1};
    tbl[11] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 7'd0,  4'd0};
    tbl[12] = '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 7'd0,  4'd0};
    tbl[13] = '{1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0, 7'd0,  4'd0};
    tbl[14] = '{1'b0, 4'b1010, 1'b0, 4'b0000, 1'b1, 7'd12, 4'd1};
    tbl[15] = '{1'b0, 4'b0000, 1'b0, 4'b1000, 1'b0, 7'd0,  4'd0};
    tbl[16] = '{1'b0, 4'b0000, 1'b0, 4'b0010, 1'b1, 7'd13, 4'd1};
    tbl[17] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 7'd11, 4'd1};
    tbl[18] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 7'd0,  4'd0};

    rst = 1'b1; fu_done = '0; cdb_stall = 1'b0; fu_tag = '0; fu_result = '0;
    for (int i = 0; i < NF; i++) set_fu(i, TW'(10 + i), 32'hC0DE_0000 + DW'(i));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();

    // Directed table: simultaneous requests, drain order, rotation.
    for (int r = 0; r < 19; r++) begin
      rst = tbl[r].rst; fu_done = tbl[r].done; cdb_stall = tbl[r].stall;
      #4;
      chk($sformatf("tbl%0d_queued", r), 64'(fu_queued), 64'(tbl[r].exp_q));
      chk($sformatf("tbl%0d_valid", r), 64'(cdb_valid), 64'(tbl[r].exp_valid));
      chk($sformatf("tbl%0d_tag", r), 64'(cdb_tag), 64'(tbl[r].exp_tag));
      chk($sformatf("tbl%0d_count", r), 64'(count), 64'(tbl[r].exp_count));
      step();
    end

    // Single request latency.
    set_fu(1, 7'h05, 32'hDEAD_BEEF);
    fu_done = 4'b0010; #4; step();
    fu_done = 4'b0000; #4; chk("single_queued", 64'(fu_queued), 64'(4'b0010)); step();
    #4;
    chk("single_valid", 64'(cdb_valid), 64'd1);
    chk("single_tag", 64'(cdb_tag), 64'h05);
    chk("single_data", 64'(cdb_data), 64'hDEAD_BEEF);
    step();
    #4; chk("single_empty", 64'(empty), 64'd1); step();

    // Full back-pressure, then one-cycle release with pop and grant together.
    cdb_stall = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < NF; i++) set_fu(i, TW'(20 + 4*b + i), 32'hF000_0000 + DW'(4*b + i));
      fu_done = 4'b1111; #4; step();
      fu_done = 4'b0000;
      repeat (5) begin #4; step(); end
    end
    set_fu(0, 7'd30, 32'h3030_3030);
    fu_done = 4'b0001; #4;
    chk("full_flag", 64'(full), 64'd1);
    chk("full_count", 64'(count), 64'd8);
    step();
    fu_done = 4'b0000; #4; chk("full_wait_queued", 64'(fu_queued), 64'd0); step();
    cdb_stall = 1'b0; #4;
    chk("release_queued", 64'(fu_queued), 64'(4'b0001));
    chk("release_count_before", 64'(count), 64'd8);
    step();
    cdb_stall = 1'b1; #4;
    chk("release_count_after", 64'(count), 64'd8);
    step();
    cdb_stall = 1'b0;
    last_tag = '0;
    for (int n = 0; n < 8; n++) begin
      #4; last_tag = cdb_tag; step();
    end
    chk("last_slot_tag", 64'(last_tag), 64'd30);

    // Reset with 3 queued and 2 pending.
    cdb_stall = 1'b1;
    for (int i = 0; i < NF; i++) set_fu(i, TW'(40 + i), 32'h4000_0000 + DW'(i));
    fu_done = 4'b0111; #4; step();
    fu_done = 4'b0000;
    repeat (3) begin #4; step(); end
    fu_done = 4'b1001; #4; chk("pre_reset_count", 64'(count), 64'd3); step();
    fu_done = 4'b0000; rst = 1'b1; #4; step();
    rst = 1'b0; #4;
    chk("post_reset_valid", 64'(cdb_valid), 64'd0);
    chk("post_reset_count", 64'(count), 64'd0);
    chk("post_reset_queued", 64'(fu_queued), 64'd0);
    fu_done = 4'b1111; cdb_stall = 1'b0;
    step();
    fu_done = 4'b0000; #4;
    chk("post_reset_first_grant", 64'(fu_queued), 64'(4'b0001));
    step();
    repeat (8) begin #4; step(); end

    // Duplicate done on a pending FU.
    cdb_stall = 1'b1;
    set_fu(0, 7'd50, 32'h5050_5050);
    pulses = 0;
    fu_done = 4'b0001; #4; pulses += int'(fu_queued[0]); step();
    fu_done = 4'b0001; #4; pulses += int'(fu_queued[0]); step();
    fu_done = 4'b0000;
    repeat (4) begin #4; pulses += int'(fu_queued[0]); step(); end
    chk("dup_pulses", 64'(pulses), 64'd1);
    #4; chk("dup_count", 64'(count), 64'd1); step();

    // Random traffic against the model.
    rst = 1'b1; #4; step();
    rst = 1'b0;
    for (int i = 0; i < NF; i++) busy[i] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      cdb_stall = ($urandom_range(0, 9) < 4);
      for (int i = 0; i < NF; i++) begin
        fu_done[i] = 1'b0;
        if (!busy[i] && $urandom_range(0, 2) == 0) begin
          set_fu(i, TW'($urandom), $urandom);
          fu_done[i] = 1'b1;
          busy[i] = 1'b1;
        end else if (busy[i] && $urandom_range(0, 5) == 0) begin
          fu_done[i] = 1'b1;
        end
      end
      #4;
      step();
      if (rst) begin
        for (int i = 0; i < NF; i++) busy[i] = 1'b0;
      end else if (m_grant >= 0) begin
        busy[m_grant] = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
